// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the multdiv multiplier sequencer.
// Holds the FSM state encoding, the operand and accumulator widths,
// and a helper that returns the magnitude of a two's complement operand.
package multdiv_pkg;

  localparam int MULT_WIDTH     = 32;
  localparam int MULT_ACC_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ACC,
    FIX
  } mult_state_t;

  // Magnitude as unsigned; -2^31 maps to 0x80000000, which is still correct unsigned
  function automatic logic [MULT_WIDTH-1:0] mag32(input logic [MULT_WIDTH-1:0] x);
    return x[MULT_WIDTH-1] ? (-x) : x;
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Start/result handshake bundle between a multdiv client and the multiplier.
// The slave side is the sequencer; the master side issues operands and start.
// busy and data_resultRDY let the client know when a new start will be taken.
interface mult_sequencer_if;
  import multdiv_pkg::*;

  logic                  ctrl_MULT;
  logic [MULT_WIDTH-1:0] data_operandA;
  logic [MULT_WIDTH-1:0] data_operandB;
  logic [MULT_WIDTH-1:0] data_result;
  logic                  data_exception;
  logic                  data_resultRDY;
  logic                  busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the least significant set bit of a 32-bit word.
// Purely combinational, zero latency.
// valid is low when the input is all zeros; index is then 0.
module lowest_set_bit (
  input  logic [31:0] value,
  output logic [4:0]  index,
  output logic        valid
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (value[i]) begin
        index = 5'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_left.sv
// Logical left barrel shifter, zero fill.
// Purely combinational, zero latency.
// No handshake; output follows inputs.
module shift_left #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] shiftamount,
  output logic [WIDTH-1:0]         result
);

  assign result = data << shiftamount;

endmodule

// File: rtl/mult_sequencer.sv
// Iterative signed 32x32 multiplier that skips zero bits of the multiplier.
// Latency: result and RDY k+2 edges after start, k = popcount(|B|).
// Start is only honoured in IDLE; requests while busy are dropped, not queued.
module mult_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  mult_sequencer_if.slave bus
);

  localparam int AW = 2 * WIDTH;

  mult_state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] mag_a, mask, mask_next;
  logic             neg;
  logic [AW-1:0]    acc, shifted, prod;
  logic [4:0]       idx;
  logic             idx_valid;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             rdy;
  logic             overflow;

  lowest_set_bit u_lsb (
    .value (mask),
    .index (idx),
    .valid (idx_valid)
  );

  // Bit 5 of the shift is tied low: multiplier bit indices never exceed 31
  shift_left #(.WIDTH(AW)) u_shift (
    .data        ({{WIDTH{1'b0}}, mag_a}),
    .shiftamount ({1'b0, idx}),
    .result      (shifted)
  );

  // mask & (mask-1) clears exactly the bit the encoder selected
  assign mask_next = mask & (mask - WIDTH'(1));
  assign prod      = neg ? (-acc) : acc;
  assign overflow  = !((&prod[AW-1:WIDTH-1]) || (~|prod[AW-1:WIDTH-1]));

  assign bus.data_result    = result;
  assign bus.data_exception = exception;
  assign bus.data_resultRDY = rdy;
  assign bus.busy           = (state != IDLE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; ACC repeats once per set multiplier bit
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.ctrl_MULT) state_next = PREP;
      PREP:    state_next = (b_reg != '0) ? ACC : FIX;
      ACC:     if (mask_next == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands, form magnitudes, accumulate, sign-fix and publish
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      mag_a     <= '0;
      mask      <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      result    <= '0;
      exception <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl_MULT) begin
            a_reg <= bus.data_operandA;
            b_reg <= bus.data_operandB;
          end
        end
        PREP: begin
          mag_a <= mag32(a_reg);
          mask  <= mag32(b_reg);
          neg   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          acc   <= '0;
        end
        ACC: begin
          if (idx_valid) acc <= acc + shifted;
          mask <= mask_next;
        end
        FIX: begin
          result    <= prod[WIDTH-1:0];
          exception <= overflow;
          rdy       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer.
// Drives inputs 1 time unit after the rising edge and samples at the same point.
// Each scenario task compares observed values against hand-computed constants.
module tb_mult_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  mult_sequencer_if bus ();

  mult_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one start, then count edges until RDY (-1 if it never comes).
  // busy_ok: busy high from E0 up to the RDY edge, low on the RDY edge.
  // rdy_fell: RDY low again one edge later.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res,
                       output logic exc, output bit busy_ok, output bit rdy_fell);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    busy_ok = (bus.busy === 1'b1);
    lat = -1;
    res = 'x;
    exc = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) begin
        lat = n;
        res = bus.data_result;
        exc = bus.data_exception;
        busy_ok = busy_ok && (bus.busy === 1'b0);
        break;
      end
      busy_ok = busy_ok && (bus.busy === 1'b1);
    end
    @(posedge clock); #1;
    rdy_fell = (bus.data_resultRDY === 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checks++; if (bus.data_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", bus.data_resultRDY); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic;
    int lat; logic [31:0] res; logic exc; bit bok, rf;
    do_op(32'd3, 32'd5, lat, res, exc, bok, rf);
    checks++; if (lat !== 4) begin failures++; $display("FAIL 3x5_latency got=%0d exp=4", lat); end
    checks++; if (res !== 32'h0000000F) begin failures++; $display("FAIL 3x5_result got=%h exp=0000000f", res); end
    checks++; if (exc !== 1'b0) begin failures++; $display("FAIL 3x5_exc got=%b exp=0", exc); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL 3x5_busy got=%b exp=1", bok); end
    checks++; if (rf !== 1'b1) begin failures++; $display("FAIL 3x5_rdy_pulse got=%b exp=1", rf); end
    do_op(-32'sd7, 32'd6, lat, res, exc, bok, rf);
    checks++; if (lat !== 4) begin failures++; $display("FAIL m7x6_latency got=%0d exp=4", lat); end
    checks++; if (res !== 32'hFFFFFFD6) begin failures++; $display("FAIL m7x6_result got=%h exp=ffffffd6", res); end
    checks++; if (exc !== 1'b0) begin failures++; $display("FAIL m7x6_exc got=%b exp=0", exc); end
  endtask

  task automatic test_zero;
    int lat; logic [31:0] res; logic exc; bit bok, rf;
    do_op(32'h7FFFFFFF, 32'h0, lat, res, exc, bok, rf);
    checks++; if (lat !== 2) begin failures++; $display("FAIL zeroB_latency got=%0d exp=2", lat); end
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL zeroB_result got=%h exp=00000000", res); end
    checks++; if (exc !== 1'b0) begin failures++; $display("FAIL zeroB_exc got=%b exp=0", exc); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL zeroB_busy got=%b exp=1", bok); end
    do_op(32'h0, 32'h80000000, lat, res, exc, bok, rf);
    checks++; if (lat !== 3) begin failures++; $display("FAIL zeroA_latency got=%0d exp=3", lat); end
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL zeroA_result got=%h exp=00000000", res); end
    checks++; if (exc !== 1'b0) begin failures++; $display("FAIL zeroA_exc got=%b exp=0", exc); end
  endtask

  task automatic test_overflow;
    int lat; logic [31:0] res; logic exc; bit bok, rf;
    do_op(32'h00010000, 32'h00010000, lat, res, exc, bok, rf);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL 2p32_result got=%h exp=00000000", res); end
    checks++; if (exc !== 1'b1) begin failures++; $display("FAIL 2p32_exc got=%b exp=1", exc); end
    do_op(32'h80000000, 32'h1, lat, res, exc, bok, rf);
    checks++; if (lat !== 3) begin failures++; $display("FAIL minx1_latency got=%0d exp=3", lat); end
    checks++; if (res !== 32'h80000000) begin failures++; $display("FAIL minx1_result got=%h exp=80000000", res); end
    checks++; if (exc !== 1'b0) begin failures++; $display("FAIL minx1_exc got=%b exp=0", exc); end
    do_op(32'h80000000, 32'hFFFFFFFF, lat, res, exc, bok, rf);
    checks++; if (res !== 32'h80000000) begin failures++; $display("FAIL minxm1_result got=%h exp=80000000", res); end
    checks++; if (exc !== 1'b1) begin failures++; $display("FAIL minxm1_exc got=%b exp=1", exc); end
  endtask

  task automatic test_worst_case;
    int lat; logic [31:0] res; logic exc; bit bok, rf;
    do_op(32'hFFFFFFFF, 32'h7FFFFFFF, lat, res, exc, bok, rf);
    checks++; if (lat !== 33) begin failures++; $display("FAIL worst_latency got=%0d exp=33", lat); end
    checks++; if (res !== 32'h80000001) begin failures++; $display("FAIL worst_result got=%h exp=80000001", res); end
    checks++; if (exc !== 1'b0) begin failures++; $display("FAIL worst_exc got=%b exp=0", exc); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL worst_busy got=%b exp=1", bok); end
    repeat (3) @(posedge clock); #1;
    checks++; if (bus.data_result !== 32'h80000001) begin failures++; $display("FAIL worst_hold got=%h exp=80000001", bus.data_result); end
  endtask

  task automatic test_ignore_busy;
    int lat;
    logic [31:0] res;
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd5;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd100; bus.data_operandB = 32'd100;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    lat = -1; res = 'x;
    for (int n = 3; n <= 40; n++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) begin lat = n; res = bus.data_result; break; end
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL ignore_latency got=%0d exp=4", lat); end
    checks++; if (res !== 32'h0000000F) begin failures++; $display("FAIL ignore_result got=%h exp=0000000f", res); end
    repeat (6) @(posedge clock); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] res;
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd5;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=4", lat); end
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd2; bus.data_operandB = 32'd7;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    lat = -1; res = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) begin lat = n; res = bus.data_result; break; end
    end
    checks++; if (lat !== 5) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=5", lat); end
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL b2b_second_result got=%h exp=0000000e", res); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_midflight;
    int lat, pulses; logic [31:0] res; logic exc; bit bok, rf;
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd5; bus.data_operandB = 32'h7FFFFFFF;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    repeat (5) @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.data_result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", bus.data_result); end
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.data_resultRDY === 1'b1) pulses++;
      @(posedge clock); #1;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL midreset_rdy_pulses got=%0d exp=0", pulses); end
    do_op(32'd2, 32'd3, lat, res, exc, bok, rf);
    checks++; if (lat !== 4) begin failures++; $display("FAIL after_reset_latency got=%0d exp=4", lat); end
    checks++; if (res !== 32'd6) begin failures++; $display("FAIL after_reset_result got=%h exp=00000006", res); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_worst_case();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
